// File: rtl/dma_axi_mem_slave.sv
// dma_axi_mem_slave: AXI4 subordinate backed by a word-addressed flop RAM.
// Optional AXI_SLV_RANGE_CHK_EN adds out-of-range SLVERR decoding.
package axi_pkg;
  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 64;
  localparam int AXI_ID_WIDTH = 4;
  localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0] aw_id;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0] aw_len;
    logic [2:0] aw_size;
    logic [1:0] aw_burst;
    logic aw_valid;
    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [AXI_STRB_WIDTH-1:0] w_strb;
    logic w_last;
    logic w_valid;
    logic b_ready;
    logic [AXI_ID_WIDTH-1:0] ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0] ar_len;
    logic [2:0] ar_size;
    logic [1:0] ar_burst;
    logic ar_valid;
    logic r_ready;
  } axi_req_t;

  typedef struct packed {
    logic aw_ready;
    logic w_ready;
    logic [AXI_ID_WIDTH-1:0] b_id;
    logic [1:0] b_resp;
    logic b_valid;
    logic ar_ready;
    logic [AXI_ID_WIDTH-1:0] r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0] r_resp;
    logic r_last;
    logic r_valid;
  } axi_resp_t;
endpackage

module dma_axi_mem_slave
  import axi_pkg::*;
#(
  parameter int MEM_DEPTH = 1024,
  parameter int DATA_WIDTH = 64,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic      clk,
  input  logic      rst,
  input  axi_req_t  axi_req_i,
  output axi_resp_t axi_resp_o
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFFS = $clog2(BYTES);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [AXI_ADDR_WIDTH-1:0] STEP =
    AXI_ADDR_WIDTH'(BYTES);

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [AXI_ID_WIDTH-1:0] w_id;
  logic [AXI_ADDR_WIDTH-1:0] w_addr;
  logic [7:0] w_len;
  logic [7:0] w_cnt;
  logic [1:0] w_burst;
  logic w_err;

  logic [AXI_ID_WIDTH-1:0] r_id;
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [7:0] r_len;
  logic [7:0] r_cnt;
  logic [1:0] r_burst;

  logic aw_hs, w_hs, ar_hs, r_hs;
  logic w_final, r_final, w_bad;
  logic w_in, r_in;
  logic [AXI_ADDR_WIDTH-1:0] w_off, r_off;
  logic [IDX_W-1:0] w_idx, r_idx;
  logic unused_ok;

  assign aw_hs = (w_state == W_IDLE)
               && axi_req_i.aw_valid;
  assign w_hs = (w_state == W_DATA)
              && axi_req_i.w_valid;
  assign ar_hs = (r_state == R_IDLE)
               && axi_req_i.ar_valid;
  assign r_hs = (r_state == R_DATA)
              && axi_req_i.r_ready;

  assign w_final = (w_cnt == w_len);
  assign r_final = (r_cnt == r_len);
  assign w_bad = axi_req_i.w_last != w_final;

  assign w_off = w_addr - BASE_ADDR;
  assign r_off = r_addr - BASE_ADDR;
  assign w_idx = w_off[OFFS +: IDX_W];
  assign r_idx = r_off[OFFS +: IDX_W];

`ifdef AXI_SLV_RANGE_CHK_EN
  localparam logic [AXI_ADDR_WIDTH:0] MEM_BYTES =
    (AXI_ADDR_WIDTH+1)'(longint'(MEM_DEPTH) * BYTES);
  assign w_in = (w_addr >= BASE_ADDR)
              && ({1'b0, w_off} < MEM_BYTES);
  assign r_in = (r_addr >= BASE_ADDR)
              && ({1'b0, r_off} < MEM_BYTES);
`else
  assign w_in = 1'b1;
  assign r_in = 1'b1;
`endif

  assign unused_ok = ^{w_off, r_off,
                       axi_req_i.aw_size,
                       axi_req_i.ar_size};

  // state registers for both independent paths
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  // write path sequencing
  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE: if (axi_req_i.aw_valid) w_next = W_DATA;
      W_DATA: if (w_hs && w_final) w_next = W_RESP;
      W_RESP: if (axi_req_i.b_ready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // read path sequencing
  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE: if (axi_req_i.ar_valid) r_next = R_DATA;
      R_DATA: if (r_hs && r_final) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // write burst context: address, beat count, sticky error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_id <= '0;
      w_addr <= '0;
      w_len <= '0;
      w_cnt <= '0;
      w_burst <= '0;
      w_err <= 1'b0;
    end else if (aw_hs) begin
      w_id <= axi_req_i.aw_id;
      w_addr <= axi_req_i.aw_addr;
      w_len <= axi_req_i.aw_len;
      w_cnt <= '0;
      w_burst <= axi_req_i.aw_burst;
      w_err <= 1'b0;
    end else if (w_hs) begin
      w_cnt <= w_cnt + 8'd1;
      if (w_burst != BURST_FIXED) w_addr <= w_addr + STEP;
      if (w_bad || !w_in) w_err <= 1'b1;
    end
  end

  // read burst context: address and beat count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_id <= '0;
      r_addr <= '0;
      r_len <= '0;
      r_cnt <= '0;
      r_burst <= '0;
    end else if (ar_hs) begin
      r_id <= axi_req_i.ar_id;
      r_addr <= axi_req_i.ar_addr;
      r_len <= axi_req_i.ar_len;
      r_cnt <= '0;
      r_burst <= axi_req_i.ar_burst;
    end else if (r_hs) begin
      r_cnt <= r_cnt + 8'd1;
      if (r_burst != BURST_FIXED) r_addr <= r_addr + STEP;
    end
  end

  // storage: byte-lane writes, contents survive reset
  always_ff @(posedge clk) begin
    if (w_hs && w_in) begin
      for (int i = 0; i < BYTES; i++) begin
        if (axi_req_i.w_strb[i])
          mem[w_idx][8*i +: 8] <= axi_req_i.w_data[8*i +: 8];
      end
    end
  end

  // handshake and response outputs decoded from state
  always_comb begin
    axi_resp_o = '0;
    axi_resp_o.aw_ready = (w_state == W_IDLE);
    axi_resp_o.w_ready = (w_state == W_DATA);
    axi_resp_o.b_valid = (w_state == W_RESP);
    axi_resp_o.b_id = w_id;
    axi_resp_o.b_resp = w_err ? RESP_SLVERR : RESP_OKAY;
    axi_resp_o.ar_ready = (r_state == R_IDLE);
    axi_resp_o.r_valid = (r_state == R_DATA);
    axi_resp_o.r_id = r_id;
    if (r_state == R_DATA) begin
      axi_resp_o.r_last = r_final;
      axi_resp_o.r_data = r_in ? mem[r_idx] : '0;
      axi_resp_o.r_resp = r_in ? RESP_OKAY : RESP_SLVERR;
    end
  end

endmodule

// File: doc/dma_axi_mem_slave.md
# dma_axi_mem_slave

AXI4 subordinate (responder) backed by an internal word-addressed flop-array memory; it is the target-side counterpart of the DMA engine's AXI master port. It accepts INCR/FIXED bursts on independent read and write paths, honours write strobes and returns OKAY/SLVERR responses. It serves as the memory endpoint in DMA subsystem integration and as a synthesizable scratch RAM on the interconnect.

## Interface
Parameters:
- MEM_DEPTH, 1024: number of DATA_WIDTH words; power of two.
- DATA_WIDTH, 64: AXI data width; must match axi_pkg.
- BASE_ADDR, 0: byte address of word 0; aligned to MEM_DEPTH*DATA_WIDTH/8.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  asynchronous, active-low reset.
- axi_req_i  in  axi_req_t  AW/W/AR channels plus bready/rready from the master.
- axi_resp_o  out  axi_resp_t  awready/wready/arready, B and R channels.

## Operation
- Word index = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8). axsize is treated as full bus width. WRAP is treated as INCR. 4 KB crossing is not checked.
- Beat address update:
  - INCR adds DATA_WIDTH/8 per beat.
  - FIXED holds the address.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: awready=1. On AW handshake, latch awid, addr, awlen, burst; beat counter=0; go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the byte lanes with wstrb set. The burst ends on beat awlen+1, regardless of wlast.
    - If wlast does not match the final-beat position on any beat, record SLVERR.
    - On the final beat, go to W_RESP.
  - W_RESP: bvalid=1, bid=latched awid, bresp=OKAY or SLVERR. Hold until bready, then go to W_IDLE.
- Read FSM R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: arready=1. On AR handshake, latch arid, addr, arlen, burst.
  - R_DATA: rvalid=1. rdata = mem[current index], read combinationally from the registered address. rid=latched arid. rlast=1 on beat arlen.
    - rresp, rdata and rlast are held stable while rready=0.
    - On an R handshake, advance the address. After rlast, go to R_IDLE.
- Read and write paths are fully independent. At most one outstanding transaction per direction.
- Same-cycle read of a word being written returns the old data.
- The memory array is not reset.

## Timing
- Reset values:
  - awready=1, arready=1.
  - wready=0, bvalid=0, rvalid=0, rlast=0.
  - bresp=0, rresp=0, bid=0, rid=0, rdata=0.
  - Both FSMs in IDLE.
- AW handshake in cycle N: wready=1 from N+1. One beat per cycle while wvalid=1.
- Last W beat in cycle M: bvalid=1 in M+1. B handshake in cycle K: awready=1 in K+1.
- AR handshake in cycle N: rvalid=1 with beat 0 in N+1. Back-to-back beats every cycle with rready=1. Last R handshake in cycle M: arready=1 in M+1.
- Minimum write turnaround: awlen+3 cycles AW-to-AW. Minimum read turnaround: arlen+2 cycles.
- Reset asserted mid-burst:
  - The burst is abandoned and outputs return to reset values asynchronously.
  - Beats already written persist. No B or R response is issued for the abandoned transaction.

## Configuration
- AXI_SLV_RANGE_CHK_EN defined:
  - Any beat whose address is outside [BASE_ADDR, BASE_ADDR + MEM_DEPTH*DATA_WIDTH/8) is decoded as out of range.
  - Out-of-range write beats are dropped, and bresp=SLVERR for the burst.
  - Out-of-range read beats return rdata=0 with rresp=SLVERR; in-range beats in the same burst return OKAY.
- Not defined: the index is taken modulo MEM_DEPTH (upper bits ignored) and all responses are OKAY, except the wlast-mismatch SLVERR.

## Test plan
- Single write, then read: AW addr 0x40, awlen=0, wdata 0xDEADBEEF_CAFEF00D, wstrb 0xFF -> bresp OKAY; AR addr 0x40, arlen=0 -> rdata 0xDEADBEEF_CAFEF00D, rlast=1, rresp OKAY.
- INCR burst with backpressure: write awlen=7 of incrementing data at 0x100; read arlen=7 with rready toggling every other cycle -> 8 beats in order, rdata stable while stalled, rlast only on beat 7.
- Strobe and FIXED burst: word 0x0 preset to all-ones; FIXED awlen=3 with wstrb 0x01, 0x02, 0x04, 0x08 and data 0 -> read back 0xFFFFFFFF_00000000.
- wlast mismatch: awlen=3 with wlast asserted on beat 1 -> all 4 beats accepted, bresp=SLVERR, awready=1 the cycle after the B handshake.
- Concurrent traffic and reset: read and write bursts of arlen=awlen=15 overlapping in time -> both complete with correct data. Repeat with rst low for one cycle at beat 5 -> all valids 0 and readys at reset values immediately; the next transaction completes normally.
- With AXI_SLV_RANGE_CHK_EN, MEM_DEPTH=1024, DATA_WIDTH=64: read at 0x2000 -> rresp SLVERR, rdata 0. Without the macro, the same read returns mem[0].
